trace_capture_buffer: RTL and testbench
=======================================

Name: trace_capture_buffer

Overview:
Capture stage directly downstream of tdc_decode. On an arm pulse it records one decoded TDC byte per clock into a DEPTH-entry trace memory, with marker bytes for the arm point and for cryptographic-core done cycles. On request it streams the trace out, one byte at a time, over the uart_tx byte handshake. Processed TDC traces are produced by this block and consumed by the host link.

Parameters:
DEPTH, 1024, trace length in bytes (power of two)
AW, 10, address width, log2(DEPTH)
DW, 8, sample/byte width
ARM_MARK, 8'd254, byte written at address 0 on arm
DONE_MARK, 8'd255, byte written when done_i is high

Ports:
clk  in  1  single clock for capture and dump
rstn  in  1  synchronous active-low reset
arm_i  in  1  start-capture pulse (AES data-ready)
sample_i  in  DW  decoded TDC value, valid every cycle
done_i  in  1  AES done/valid flag, sampled every capture cycle
dump_req_i  in  1  start-dump pulse
tx_done_i  in  1  uart_tx byte-complete pulse
tx_byte_o  out  DW  byte presented to uart_tx
tx_dv_o  out  1  one-cycle transmit strobe
capture_busy_o  out  1  high while capturing
capture_done_o  out  1  one-cycle pulse when the last entry is written
dump_busy_o  out  1  high from dump accept to last tx_done_i

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; all outputs 0; write/read pointers 0; valid flag cleared. Memory contents are not cleared. A reset mid-capture or mid-dump aborts immediately, and no further tx_dv_o is issued.
- States: IDLE, CAPTURE, DUMP_RD, DUMP_TX, DUMP_WAIT.
- IDLE + arm_i: write ARM_MARK to mem[0], wp<=1, capture_busy_o<=1, go CAPTURE.
- CAPTURE, each cycle: mem[wp] <= done_i ? DONE_MARK : clamp(sample_i); wp<=wp+1.
- clamp: a sample value of 254 or 255 is written as 253, so that marker bytes stay unique.
- When wp==DEPTH-1 is written: capture_busy_o<=0, capture_done_o pulses 1 cycle, valid<=1, wp<=0, go IDLE. Total entries = DEPTH; the pointer never wraps inside a capture.
- arm_i is ignored outside IDLE. dump_req_i is ignored outside IDLE and when valid=0.
- If arm_i and dump_req_i are both high in IDLE, arm wins.
- IDLE + dump_req_i + valid: rp<=0, dump_busy_o<=1, go DUMP_RD.
- DUMP_RD: synchronous memory read of mem[rp] (1-cycle latency), go DUMP_TX.
- DUMP_TX: tx_byte_o<=read data, tx_dv_o=1 for exactly one cycle, go DUMP_WAIT.
- tx_byte_o holds its value until the next DUMP_TX.
- DUMP_WAIT: on tx_done_i:
  - if rp==DEPTH-1: dump_busy_o<=0, go IDLE.
  - else: rp<=rp+1, go DUMP_RD.
- tx_done_i outside DUMP_WAIT is ignored.
- Latency: dump_req_i accepted at cycle N gives tx_dv_o high at cycle N+2. Each tx_done_i gives the next tx_dv_o 2 cycles later.
- valid stays set after a dump, so the same trace can be re-dumped. A new arm overwrites the trace.

Optional Feature:
TRACE_HEADER_EN:
- Defined: before byte 0 of every dump, two header bytes 8'hA5 then 8'h5A are sent through the same TX/WAIT handshake. A dump totals DEPTH+2 strobes.
- Undefined: a dump is exactly DEPTH strobes, and no header logic is generated.

Decomposition:
- Shared package trace_pkg: state enum, ARM_MARK/DONE_MARK/CLAMP_MAX (253) constants, header byte constants.
- One natural sub-module: trace_ram, a simple dual-port RAM (DEPTH x DW) with one write port and one registered read port, inferable as BRAM.

Test Plan:
- Reset mid-capture: arm, assert rstn=0 at sample 100 -> next cycle all outputs 0, state IDLE; dump_req_i then ignored (valid=0).
- Basic capture: arm, sample_i=wp[7:0] ramp, done_i=0 -> capture_done_o exactly DEPTH-1 cycles after arm. Dump gives byte0=254, then bytes i[7:0] with 254/255 clamped to 253.
- Done markers: done_i high for capture cycles 300-309 -> dumped bytes 300-309 = 255; neighbours unaffected.
- Handshake: tx_done_i returned 10 cycles after each tx_dv_o -> exactly DEPTH one-cycle strobes, each 2 cycles after the prior tx_done_i; dump_busy_o falls on the last tx_done_i.
- Conflicts: arm_i during a dump and dump_req_i during capture -> both ignored. Simultaneous arm_i+dump_req_i in IDLE -> capture starts.
- TRACE_HEADER_EN defined -> first two bytes A5,5A, then 254, with DEPTH+2 strobes total.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared FSM states and marker/header byte constants for the trace capture buffer
//
// Purpose: constants shared by trace_capture_buffer and its bench-facing users.
//   ST_*           FSM state encodings (IDLE, CAPTURE, DUMP_RD, DUMP_TX, DUMP_WAIT)
//   ARM_MARK_BYTE  byte stored at address 0 when a capture is armed
//   DONE_MARK_BYTE byte stored for capture cycles with done_i high
//   CLAMP_MAX      largest sample value stored verbatim; anything above is saturated here
//   HDR_BYTE0/1    dump header bytes used when TRACE_HEADER_EN is defined
package trace_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CAPTURE   = 3'd1;
   localparam logic [2:0] ST_DUMP_RD   = 3'd2;
   localparam logic [2:0] ST_DUMP_TX   = 3'd3;
   localparam logic [2:0] ST_DUMP_WAIT = 3'd4;

   localparam logic [7:0] ARM_MARK_BYTE  = 8'd254;
   localparam logic [7:0] DONE_MARK_BYTE = 8'd255;
   localparam logic [7:0] CLAMP_MAX      = 8'd253;

   localparam logic [7:0] HDR_BYTE0 = 8'hA5;
   localparam logic [7:0] HDR_BYTE1 = 8'h5A;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port trace memory, one write port and one registered read port
//
// Ports:
//   clk    clock for both ports
//   we     write enable; waddr/wdata written at the clock edge
//   re     read enable; rdata <= mem[raddr] at the clock edge (1-cycle latency)
//   rdata  registered read data, holds between reads
// Contents are never reset so the array maps onto block RAM.
module trace_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/trace_capture_buffer.sv
// rtl/trace_capture_buffer.sv - captures one decoded TDC byte per clock after arm and dumps the trace over a uart_tx byte handshake
//
// Optional feature macro: TRACE_HEADER_EN (prefixes every dump with bytes A5, 5A).
//
// Ports:
//   clk, rstn        clock and synchronous active-low reset
//   arm_i            start-capture pulse; mem[0] gets ARM_MARK, then DEPTH-1 samples follow
//   sample_i         decoded TDC value, one per cycle
//   done_i           crypto-core done flag; its cycle is stored as DONE_MARK
//   dump_req_i       start-dump pulse, honoured only in IDLE with a valid trace
//   tx_done_i        uart_tx byte-complete pulse, honoured only while waiting on a byte
//   tx_byte_o        byte presented to uart_tx, held until the next strobe
//   tx_dv_o          one-cycle transmit strobe
//   capture_busy_o   high while capturing
//   capture_done_o   one-cycle pulse after the last entry is written
//   dump_busy_o      high from dump accept to the last tx_done_i
module trace_capture_buffer
   import trace_pkg::*;
#(
   parameter int            DEPTH     = 1024,
   parameter int            AW        = 10,
   parameter int            DW        = 8,
   parameter logic [DW-1:0] ARM_MARK  = DW'(ARM_MARK_BYTE),
   parameter logic [DW-1:0] DONE_MARK = DW'(DONE_MARK_BYTE)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          arm_i,
   input  logic [DW-1:0] sample_i,
   input  logic          done_i,
   input  logic          dump_req_i,
   input  logic          tx_done_i,
   output logic [DW-1:0] tx_byte_o,
   output logic          tx_dv_o,
   output logic          capture_busy_o,
   output logic          capture_done_o,
   output logic          dump_busy_o
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [2:0]    state;
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          valid;

   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic [DW-1:0] sample_clamped;

`ifdef TRACE_HEADER_EN
   logic          hdr_active;
   logic          hdr_idx;
`endif

   // Samples that would collide with the marker bytes are saturated below them.
   assign sample_clamped = (sample_i > DW'(CLAMP_MAX)) ? DW'(CLAMP_MAX) : sample_i;

   // Write port is driven straight from the FSM state; gated by rstn so a
   // reset edge during capture leaves the memory untouched.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = wp;
      ram_wdata = done_i ? DONE_MARK : sample_clamped;
      if (rstn) begin
         if (state == ST_IDLE && arm_i) begin
            ram_we    = 1'b1;
            ram_waddr = '0;
            ram_wdata = ARM_MARK;
         end else if (state == ST_CAPTURE) begin
            ram_we = 1'b1;
         end
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (state == ST_DUMP_RD),
      .raddr (rp),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state          <= ST_IDLE;
         wp             <= '0;
         rp             <= '0;
         valid          <= 1'b0;
         tx_byte_o      <= '0;
         tx_dv_o        <= 1'b0;
         capture_busy_o <= 1'b0;
         capture_done_o <= 1'b0;
         dump_busy_o    <= 1'b0;
`ifdef TRACE_HEADER_EN
         hdr_active     <= 1'b0;
         hdr_idx        <= 1'b0;
`endif
      end else begin
         tx_dv_o        <= 1'b0;
         capture_done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               // arm has priority over a simultaneous dump request
               if (arm_i) begin
                  wp             <= AW'(1);
                  capture_busy_o <= 1'b1;
                  state          <= ST_CAPTURE;
               end else if (dump_req_i && valid) begin
                  rp          <= '0;
                  dump_busy_o <= 1'b1;
                  state       <= ST_DUMP_RD;
`ifdef TRACE_HEADER_EN
                  hdr_active  <= 1'b1;
                  hdr_idx     <= 1'b0;
`endif
               end
            end
            ST_CAPTURE: begin
               if (wp == LAST_ADDR) begin
                  capture_busy_o <= 1'b0;
                  capture_done_o <= 1'b1;
                  valid          <= 1'b1;
                  wp             <= '0;
                  state          <= ST_IDLE;
               end else begin
                  wp <= wp + AW'(1);
               end
            end
            ST_DUMP_RD: begin
               state <= ST_DUMP_TX;
            end
            ST_DUMP_TX: begin
`ifdef TRACE_HEADER_EN
               if (hdr_active) begin
                  tx_byte_o <= hdr_idx ? DW'(HDR_BYTE1) : DW'(HDR_BYTE0);
               end else begin
                  tx_byte_o <= ram_rdata;
               end
`else
               tx_byte_o <= ram_rdata;
`endif
               tx_dv_o <= 1'b1;
               state   <= ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
               if (tx_done_i) begin
`ifdef TRACE_HEADER_EN
                  // header bytes reuse the RD/TX/WAIT path without advancing rp
                  if (hdr_active) begin
                     if (hdr_idx) begin
                        hdr_active <= 1'b0;
                     end
                     hdr_idx <= 1'b1;
                     state   <= ST_DUMP_RD;
                  end else
`endif
                  if (rp == LAST_ADDR) begin
                     dump_busy_o <= 1'b0;
                     state       <= ST_IDLE;
                  end else begin
                     rp    <= rp + AW'(1);
                     state <= ST_DUMP_RD;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb/tb_trace_capture_buffer.sv - directed table-driven bench for trace_capture_buffer
module tb_trace_capture_buffer;

   localparam int DEPTH = 1024;
`ifdef TRACE_HEADER_EN
   localparam int HOFS = 2;
`else
   localparam int HOFS = 0;
`endif
   localparam int NSTR = DEPTH + HOFS;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       arm_i = 1'b0;
   logic [7:0] sample_i = 8'd0;
   logic       done_i = 1'b0;
   logic       dump_req_i = 1'b0;
   logic       tx_done_i = 1'b0;
   logic [7:0] tx_byte_o;
   logic       tx_dv_o;
   logic       capture_busy_o;
   logic       capture_done_o;
   logic       dump_busy_o;

   int nchk = 0;
   int nerr = 0;
   int cyc = 0;

   logic [7:0] exp_b [DEPTH];
   logic [7:0] got   [NSTR];
   logic [7:0] got1  [DEPTH];
   logic [7:0] got2  [DEPTH];

   typedef struct {
      int addr;
      int exp1;
      int exp2;
   } vec_t;
   vec_t vecs [18];

   trace_capture_buffer dut (
      .clk            (clk),
      .rstn           (rstn),
      .arm_i          (arm_i),
      .sample_i       (sample_i),
      .done_i         (done_i),
      .dump_req_i     (dump_req_i),
      .tx_done_i      (tx_done_i),
      .tx_byte_o      (tx_byte_o),
      .tx_dv_o        (tx_dv_o),
      .capture_busy_o (capture_busy_o),
      .capture_done_o (capture_done_o),
      .dump_busy_o    (dump_busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp_v);
      nchk++;
      if (act !== exp_v) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_tx_byte"}, int'(tx_byte_o), 0);
      chk({tag, "_tx_dv"}, int'(tx_dv_o), 0);
      chk({tag, "_cap_busy"}, int'(capture_busy_o), 0);
      chk({tag, "_cap_done"}, int'(capture_done_o), 0);
      chk({tag, "_dump_busy"}, int'(dump_busy_o), 0);
   endtask

   // Pulses dump_req_i and checks nothing starts (no valid trace expected).
   task automatic chk_dump_ignored(input string tag);
      int bad = 0;
      dump_req_i = 1'b1;
      @(negedge clk);
      dump_req_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (dump_busy_o || tx_dv_o) bad++;
         @(negedge clk);
      end
      chk({tag, "_dump_ignored"}, bad, 0);
   endtask

   // mode 0: sample = addr, done_i on addrs 300..309; mode 1: sample = 3*addr.
   task automatic do_capture(input int mode, input bit both, input int dreq_at, input int reset_at);
      int a, done_cyc = -1, pulses = 0, busy_bad = 0, dbusy_bad = 0;
      logic [7:0] s;
      arm_i = 1'b1;
      dump_req_i = both;
      @(negedge clk);
      a = cyc;
      arm_i = 1'b0;
      dump_req_i = 1'b0;
      chk("arm_cap_busy", int'(capture_busy_o), 1);
      if (both) chk("arm_wins_dump_busy", int'(dump_busy_o), 0);
      exp_b[0] = 8'd254;
      for (int k = 1; k < DEPTH; k++) begin
         s = (mode == 0) ? 8'(k) : 8'(k * 3);
         sample_i = s;
         done_i = (mode == 0) && (k >= 300) && (k <= 309);
         dump_req_i = (k == dreq_at);
         if (k == reset_at) begin
            rstn = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
            done_i = 1'b0;
            dump_req_i = 1'b0;
            chk_idle_outputs("rst_mid_capture");
            return;
         end
         exp_b[k] = done_i ? 8'd255 : ((s >= 8'd254) ? 8'd253 : s);
         @(negedge clk);
         if (capture_done_o) begin
            pulses++;
            done_cyc = cyc;
         end
         if (k < DEPTH - 1 && !capture_busy_o) busy_bad++;
         if (dump_busy_o) dbusy_bad++;
      end
      done_i = 1'b0;
      dump_req_i = 1'b0;
      @(negedge clk);
      if (capture_done_o) pulses++;
      chk("cap_done_latency", done_cyc - a, DEPTH - 1);
      chk("cap_done_pulses", pulses, 1);
      chk("cap_busy_during", busy_bad, 0);
      chk("cap_no_dump_during", dbusy_bad, 0);
      chk("cap_busy_after", int'(capture_busy_o), 0);
   endtask

   // Full dump, tx_done_i returned 10 cycles after each strobe; arm_i pulsed after strobe arm_at.
   task automatic do_dump(input int arm_at);
      int last_evt, t, got_n = 0, lat_bad = 0, dv_bad = 0, busy_bad = 0, cap_bad = 0, stray = 0;
      dump_req_i = 1'b1;
      @(negedge clk);
      last_evt = cyc;
      dump_req_i = 1'b0;
      chk("dump_busy_on", int'(dump_busy_o), 1);
      for (int i = 0; i < NSTR; i++) begin
         t = 0;
         while (!tx_dv_o && t < 30) begin
            @(negedge clk);
            t++;
         end
         if (!tx_dv_o) begin
            chk("dump_strobe_seen", i, -1);
            break;
         end
         if (cyc - last_evt != 2) lat_bad++;
         if (!dump_busy_o) busy_bad++;
         got[i] = tx_byte_o;
         got_n++;
         if (i == arm_at) arm_i = 1'b1;
         @(negedge clk);
         arm_i = 1'b0;
         if (tx_dv_o) dv_bad++;
         if (capture_busy_o) cap_bad++;
         repeat (8) @(negedge clk);
         tx_done_i = 1'b1;
         @(negedge clk);
         last_evt = cyc;
         tx_done_i = 1'b0;
         if (i < NSTR - 1 && !dump_busy_o) busy_bad++;
      end
      chk("dump_strobes", got_n, NSTR);
      chk("dump_strobe_latency", lat_bad, 0);
      chk("dump_strobe_width", dv_bad, 0);
      chk("dump_busy_held", busy_bad, 0);
      chk("dump_arm_ignored", cap_bad, 0);
      chk("dump_busy_off", int'(dump_busy_o), 0);
      for (int i = 0; i < 20; i++) begin
         tx_done_i = (i == 3);
         @(negedge clk);
         if (tx_dv_o) stray++;
      end
      tx_done_i = 1'b0;
      chk("dump_no_stray_strobe", stray, 0);
`ifdef TRACE_HEADER_EN
      chk("hdr_byte0", int'(got[0]), 8'hA5);
      chk("hdr_byte1", int'(got[1]), 8'h5A);
`endif
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int m;
      int bad;

      //         addr  trace1 trace2(3*addr)
      vecs[0]  = '{0,    254, 254};
      vecs[1]  = '{1,    1,   3};
      vecs[2]  = '{84,   84,  252};
      vecs[3]  = '{85,   85,  253};
      vecs[4]  = '{86,   86,  2};
      vecs[5]  = '{170,  170, 253};
      vecs[6]  = '{253,  253, 247};
      vecs[7]  = '{254,  253, 250};
      vecs[8]  = '{255,  253, 253};
      vecs[9]  = '{256,  0,   0};
      vecs[10] = '{299,  43,  129};
      vecs[11] = '{300,  255, 132};
      vecs[12] = '{305,  255, 147};
      vecs[13] = '{309,  255, 159};
      vecs[14] = '{310,  54,  162};
      vecs[15] = '{1021, 253, 247};
      vecs[16] = '{1022, 253, 250};
      vecs[17] = '{1023, 253, 253};

      repeat (3) @(negedge clk);
      rstn = 1'b1;
      chk_idle_outputs("reset");

      // abort a capture at sample 100; trace must not become valid
      do_capture(0, 1'b0, -1, 100);
      @(negedge clk);
      chk_idle_outputs("after_rst_capture");
      chk_dump_ignored("rst_capture");

      // trace 1: ramp with done markers
      do_capture(0, 1'b0, -1, -1);
      do_dump(5);
      m = 0;
      for (int i = 0; i < DEPTH; i++) begin
         got1[i] = got[i + HOFS];
         if (got1[i] !== exp_b[i]) m++;
      end
      chk("trace1_all_bytes_bad", m, 0);

      // trace 2: simultaneous arm+dump starts a capture; dump_req mid-capture ignored
      do_capture(1, 1'b1, 50, -1);
      do_dump(-1);
      m = 0;
      for (int i = 0; i < DEPTH; i++) begin
         got2[i] = got[i + HOFS];
         if (got2[i] !== exp_b[i]) m++;
      end
      chk("trace2_all_bytes_bad", m, 0);

      foreach (vecs[j]) begin
         chk($sformatf("trace1_byte%0d", vecs[j].addr), int'(got1[vecs[j].addr]), vecs[j].exp1);
         chk($sformatf("trace2_byte%0d", vecs[j].addr), int'(got2[vecs[j].addr]), vecs[j].exp2);
      end

      // reset during a dump: abort, no further strobes, trace invalidated
      dump_req_i = 1'b1;
      @(negedge clk);
      dump_req_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_abort_strobe", int'(tx_dv_o), 1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk_idle_outputs("rst_mid_dump");
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         tx_done_i = (i == 5) || (i == 15);
         @(negedge clk);
         if (tx_dv_o || dump_busy_o) bad++;
      end
      tx_done_i = 1'b0;
      chk("rst_dump_no_strobe", bad, 0);
      chk_dump_ignored("rst_dump");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
